// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and registered result/flags.
// Single-cycle ops complete at the accept edge; MUL/DIVU/REMU iterate one bit per cycle.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [2:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int MSB   = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_MUL  = 3'b011,
    OP_DIVU = 3'b100,
    OP_REMU = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;       // MUL: multiplicand; DIV: dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] b_q, b_d;       // MUL: multiplier; DIV: divisor
  logic [WIDTH-1:0] acc_q, acc_d;   // MUL: partial product; DIV: partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  op_t              in_op;
  logic             add_sub;
  logic [WIDTH-1:0] add_b, add_r;
  logic [WIDTH-1:0] alu_r;
  logic             alu_ovf;
  logic             div_zero;
  logic             is_iter;

  assign in_op = op_t'(aluc);

  // Single-cycle results straight from the input operands, registered at the accept edge.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_sub  = (in_op == OP_SUB);
    add_b    = add_sub ? ~src2 : src2;
    add_r    = src1 + add_b + {{(WIDTH-1){1'b0}}, add_sub};
    div_zero = (src2 == '0);
    is_iter  = (in_op == OP_MUL) ||
               (((in_op == OP_DIVU) || (in_op == OP_REMU)) && !div_zero);
    alu_r    = '0;
    alu_ovf  = 1'b0;
    case (in_op)
      OP_AND:  alu_r = src1 & src2;
      OP_OR:   alu_r = src1 | src2;
      OP_ADD,
      OP_SUB: begin
        alu_r   = add_r;
        alu_ovf = (src1[MSB] == add_b[MSB]) && (add_r[MSB] != src1[MSB]);
      end
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_DIVU: alu_r = '1;    // only taken here when the divisor is zero
      OP_REMU: alu_r = src1;
      default: alu_r = '0;    // MUL always iterates
    endcase
  end

  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] it_a, it_b, it_acc;

  // One shift-add or restoring-division step on the latched operands.
  always_comb begin
    rem_sh = {acc_q, a_q[MSB]};
    trial  = rem_sh - {1'b0, b_q};
    it_a   = a_q;
    it_b   = b_q;
    it_acc = acc_q;
    if (op_q == OP_MUL) begin
      it_acc = acc_q + (b_q[0] ? a_q : '0);
      it_a   = a_q << 1;
      it_b   = b_q >> 1;
    end else if (!trial[WIDTH]) begin
      it_acc = trial[WIDTH-1:0];
      it_a   = {a_q[MSB-1:0], 1'b1};
    end else begin
      it_acc = rem_sh[WIDTH-1:0];
      it_a   = {a_q[MSB-1:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = in_op;
          a_d   = src1;
          b_d   = src2;
          acc_d = '0;
          cnt_d = '0;
          if (is_iter) begin
            state_d = S_BUSY;
          end else begin
            result_d = alu_r;
            zero_d   = (alu_r == '0);
            ovf_d    = alu_ovf;
            dz_d     = ((in_op == OP_DIVU) || (in_op == OP_REMU)) && div_zero;
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        a_d   = it_a;
        b_d   = it_b;
        acc_d = it_acc;
        if (cnt_q == LAST_CNT) begin
          result_d = (op_q == OP_DIVU) ? it_a : it_acc;
          zero_d   = (result_d == '0);
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values; all of them are plain registers cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed vector table, random ops against
// an arithmetic reference model, backpressure and reset-abort sequences.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [2:0]   aluc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         dz;

  int total = 0;
  int bad   = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .aluc      (aluc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ovf;
    logic         dz;
    int           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ovf;
    logic         dz;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    e.res = '0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        e.res = a + b;
        s = sa + sb;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: begin
        e.res = W'(64'(a) * 64'(b));
        e.lat = W + 1;
      end
      3'd4: if (b == 0) begin e.res = '1; e.dz = 1'b1; end
            else begin e.res = a / b; e.lat = W + 1; end
      3'd5: if (b == 0) begin e.res = a; e.dz = 1'b1; end
            else begin e.res = a % b; e.lat = W + 1; end
      3'd6: begin
        e.res = a - b;
        s = sa - sb;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: e.res = (sa < sb) ? 1 : 0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Present one op, wait for out_valid; inputs are scrambled once accepted.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    src1 = a;
    src2 = b;
    aluc = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = $urandom;
    src2 = $urandom;
    aluc = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      src1 = $urandom;
      src2 = $urandom;
      aluc = 3'($urandom);
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input exp_t e);
    int lat;
    start_op(op, a, b, lat);
    check({tag, "_result"}, result, e.res);
    check({tag, "_zero"}, zero, e.z);
    check({tag, "_ovf"}, ovf, e.ovf);
    check({tag, "_dz"}, dz, e.dz);
    check({tag, "_latency"}, lat, e.lat);
    drain();
  endtask

  vec_t vecs[15];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    exp_t e;
    int   lat;
    logic seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; aluc = '0;

    vecs[0]  = '{3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'd6, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'd3, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b0, 33};
    vecs[4]  = '{3'd4, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 33};
    vecs[5]  = '{3'd5, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 33};
    vecs[6]  = '{3'd4, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{3'd5, 32'd9,        32'd0,        32'd9,        1'b0, 1'b0, 1'b1, 1};
    vecs[8]  = '{3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'd1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{3'd6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[11] = '{3'd7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[12] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 33};
    vecs[13] = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33};
    vecs[14] = '{3'd4, 32'd5,        32'd7,        32'd0,        1'b1, 1'b0, 1'b0, 33};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dz", dz, 0);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      e.res = vecs[i].res; e.z = vecs[i].z; e.ovf = vecs[i].ovf;
      e.dz = vecs[i].dz; e.lat = vecs[i].lat;
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    // Backpressure: result/flags hold, new requests ignored
    start_op(3'd2, 32'h7FFFFFFF, 32'h1, lat);
    in_valid = 1'b1; src1 = 32'd3; src2 = 32'd3; aluc = 3'd6;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_result", i), result, 32'h80000000);
      check($sformatf("bp%0d_ovf", i), ovf, 1);
      check($sformatf("bp%0d_zero", i), zero, 0);
      check($sformatf("bp%0d_out_valid", i), out_valid, 1);
      check($sformatf("bp%0d_in_ready", i), in_ready, 0);
    end
    in_valid = 1'b0;
    drain();
    check("bp_after_drain_out_valid", out_valid, 0);
    check("bp_after_drain_in_ready", in_ready, 1);
    run_and_check("bp_next", 3'd2, 32'd3, 32'd4, model(3'd2, 32'd3, 32'd4));

    // Reset pulse at BUSY cycle 10 of a MUL
    in_valid = 1'b1; src1 = 32'd3; src2 = 32'd5; aluc = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("abort_no_output", seen, 0);
    run_and_check("abort_next", 3'd3, 32'd6, 32'd7, model(3'd3, 32'd6, 32'd7));

    // Random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_and_check($sformatf("rnd%0d_op%0d", i, op), op, a, b, model(op, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
